// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the bus to clk_i, shifts in MSB-first words
// and presents held left/right samples with a one-cycle pair-valid strobe.
module i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  output logic                  frame_err_o
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(SLOT_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  logic [SYNC_STAGES-1:0] sck_sr, ws_sr, sd_sr;
  logic                   sck_prev, ws_prev;
  logic                   sck_sync, ws_s, sd_s, bit_ev, ws_chg;

  state_t                 state, state_n;
  logic [CW-1:0]          bit_cnt, cnt_n;
  logic                   chan, chan_n;
  logic                   got_left, got_n;
  logic [DATA_WIDTH-2:0]  shreg, shreg_n;
  logic [DATA_WIDTH-1:0]  left_n, right_n;
  logic                   valid_n, err_n;

  assign sck_sync = sck_sr[SYNC_STAGES-1];
  assign ws_s     = ws_sr[SYNC_STAGES-1];
  assign sd_s     = sd_sr[SYNC_STAGES-1];
  assign bit_ev   = sck_sync & ~sck_prev;
  // The bit on a WS-change event still belongs to the previous slot.
  assign ws_chg   = bit_ev & (ws_s != ws_prev);

  // Input synchronizers, rising-edge detect and ws history.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sck_sr   <= '0;
      ws_sr    <= '0;
      sd_sr    <= '0;
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck_i};
      ws_sr    <= {ws_sr[SYNC_STAGES-2:0], ws_i};
      sd_sr    <= {sd_sr[SYNC_STAGES-2:0], sd_i};
      sck_prev <= sck_sync;
      if (bit_ev) ws_prev <= ws_s;
    end
  end

  // State and datapath registers; clr_i overrides any bit event.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      chan        <= 1'b0;
      got_left    <= 1'b0;
      shreg       <= '0;
      left_o      <= '0;
      right_o     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= cnt_n;
      chan        <= chan_n;
      got_left    <= got_n;
      shreg       <= shreg_n;
      left_o      <= left_n;
      right_o     <= right_n;
      valid_o     <= valid_n;
      frame_err_o <= err_n;
    end
  end

  // Next-state: word framing, capture, pairing and error detection.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    chan_n  = chan;
    got_n   = got_left;
    shreg_n = shreg;
    left_n  = left_o;
    right_n = right_o;
    valid_n = 1'b0;
    err_n   = frame_err_o;
    if (bit_ev) begin
      case (state)
        IDLE: begin
          if (ws_chg) begin
            cnt_n   = '0;
            chan_n  = ws_s;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (ws_chg) begin
            // Short word: drop it and start over on the new channel.
            err_n  = 1'b1;
            got_n  = 1'b0;
            cnt_n  = '0;
            chan_n = ws_s;
          end else begin
            shreg_n = {shreg[DATA_WIDTH-3:0], sd_s};
            cnt_n   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) begin
              state_n = PAD;
              if (!chan) begin
                left_n = {shreg, sd_s};
                got_n  = 1'b1;
              end else begin
                right_n = {shreg, sd_s};
                if (got_left) begin
                  valid_n = 1'b1;
                  got_n   = 1'b0;
                end
              end
            end
          end
        end
        PAD: begin
          if (ws_chg) begin
            cnt_n   = '0;
            chan_n  = ws_s;
            state_n = SHIFT;
          end else if (bit_cnt == LAST_SLOT) begin
            // Slot overran without a WS change: resync from IDLE.
            cnt_n   = SLOT_END;
            err_n   = 1'b1;
            got_n   = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = bit_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives an I2S bus (8 clk per sck), queues expected
// sample pairs as frames are sent and pops them on each valid_o pulse.
module tb_i2s_rx;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        clr_i, sck_i, ws_i, sd_i;
  logic [23:0] left_o, right_o;
  logic        valid_o, frame_err_o;

  int    tests = 0, fails = 0;
  int    cyc = 0;
  int    rise_cyc = 0, rise24_cyc = 0, valid_cyc = 0, n_valid = 0;
  logic  prev_valid = 1'b0;
  pair_t exp_q[$];

  i2s_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .clr_i(clr_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .left_o(left_o), .right_o(right_o), .valid_o(valid_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One clk period; checks every valid_o pulse against the scoreboard.
  task automatic tick();
    pair_t p;
    @(negedge clk);
    if (valid_o) begin
      n_valid++;
      valid_cyc = cyc;
      tests++;
      if (prev_valid) begin
        fails++;
        $display("FAIL valid_width: valid_o high on consecutive cycles, required one-cycle pulse");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: left=%h right=%h, required no pulse", left_o, right_o);
      end else begin
        p = exp_q.pop_front();
        if (left_o !== p.l || right_o !== p.r) begin
          fails++;
          $display("FAIL pair: got left=%h right=%h, required left=%h right=%h",
                   left_o, right_o, p.l, p.r);
        end
      end
    end
    prev_valid = valid_o;
  endtask

  // One sck period: low 4 clk (data/ws change), high 4 clk.
  // clr_act: 1 asserts clr_i, 0 releases it, -1 leaves it.
  task automatic send_bit(input logic ws, input logic sd, input int clr_act);
    sck_i = 1'b0;
    ws_i  = ws;
    sd_i  = sd;
    if (clr_act == 1) clr_i = 1'b1;
    if (clr_act == 0) clr_i = 1'b0;
    repeat (4) tick();
    sck_i    = 1'b1;
    rise_cyc = cyc;
    repeat (4) tick();
  endtask

  // Slot of nbits events; event 0 carries the prior slot's last bit,
  // events 1..24 carry data MSB first, the rest are zero padding.
  task automatic send_slot(input logic ws, input logic [23:0] data, input int nbits,
                           input int clr_on, input int clr_off);
    logic b;
    int   act;
    for (int k = 0; k < nbits; k++) begin
      b   = (k >= 1 && k <= 24) ? data[24-k] : 1'b0;
      act = (k == clr_on) ? 1 : ((k == clr_off) ? 0 : -1);
      send_bit(ws, b, act);
      if (k == 24) rise24_cyc = rise_cyc;
    end
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
    send_slot(1'b0, l, 32, -1, -1);
    send_slot(1'b1, r, 32, -1, -1);
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic test_reset();
    clr_i = 1'b1; sck_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
    repeat (4) tick();
    chk("reset_left", left_o, 24'h0);
    chk("reset_right", right_o, 24'h0);
    chk("reset_valid", {23'h0, valid_o}, 24'h0);
    chk("reset_err", {23'h0, frame_err_o}, 24'h0);
    clr_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int n0;
    send_slot(1'b1, 24'h5A5A5A, 32, -1, -1);  // lone right: no pulse
    chk("lone_right", right_o, 24'h5A5A5A);
    n0 = n_valid;
    send_pair(24'h123456, 24'hABCDEF);
    chk("basic_pulses", 24'(n_valid - n0), 24'd1);
    chk("basic_latency", 24'(valid_cyc - rise24_cyc), 24'd3);
    chk("basic_left", left_o, 24'h123456);
    chk("basic_right", right_o, 24'hABCDEF);
    chk("basic_err", {23'h0, frame_err_o}, 24'h0);
  endtask

  task automatic test_frames();
    logic [23:0] lv [5];
    int n0;
    lv[0] = 24'h000001; lv[1] = 24'h7FFFFF; lv[2] = 24'h800000;
    lv[3] = 24'hFFFFFF; lv[4] = 24'h000000;
    n0 = n_valid;
    for (int i = 0; i < 5; i++) send_pair(lv[i], lv[i] ^ 24'hC3A5F0);
    chk("frames_pulses", 24'(n_valid - n0), 24'd5);
    chk("frames_queue", 24'(exp_q.size()), 24'd0);
  endtask

  task automatic test_ws_err();
    int n0;
    n0 = n_valid;
    send_slot(1'b0, 24'hFFFFFF, 17, -1, -1);  // only 16 data bits
    send_slot(1'b1, 24'h0F0F0F, 32, -1, -1);
    chk("wserr_flag", {23'h0, frame_err_o}, 24'h1);
    chk("wserr_left_held", left_o, 24'h000000);
    chk("wserr_right", right_o, 24'h0F0F0F);
    chk("wserr_no_pulse", 24'(n_valid - n0), 24'd0);
    send_pair(24'h13579B, 24'h2468AC);
    chk("wserr_recover", 24'(n_valid - n0), 24'd1);
    chk("wserr_sticky", {23'h0, frame_err_o}, 24'h1);
  endtask

  task automatic test_clr_mid();
    int n0;
    n0 = n_valid;
    clr_i = 1'b1;
    send_slot(1'b1, 24'h111111, 32, -1, 12);  // released mid-right-slot
    send_slot(1'b0, 24'h222222, 32, 10, 11);  // pulse during left bit 10
    chk("clr_left", left_o, 24'h0);
    chk("clr_right", right_o, 24'h0);
    chk("clr_err", {23'h0, frame_err_o}, 24'h0);
    send_slot(1'b1, 24'h333333, 32, -1, -1);
    chk("clr_unpaired_right", right_o, 24'h333333);
    chk("clr_no_pulse", 24'(n_valid - n0), 24'd0);
    send_pair(24'h444444, 24'h555555);
    chk("clr_first_pair", 24'(n_valid - n0), 24'd1);
  endtask

  task automatic test_pad_timeout();
    int n0;
    n0 = n_valid;
    send_slot(1'b0, 24'h654321, 32, -1, -1);
    chk("pad_no_err_yet", {23'h0, frame_err_o}, 24'h0);
    send_bit(1'b0, 1'b0, -1);                  // bit_cnt reaches SLOT_WIDTH
    chk("pad_err", {23'h0, frame_err_o}, 24'h1);
    for (int i = 0; i < 39; i++) send_bit(1'b0, 1'b0, -1);
    send_slot(1'b1, 24'h0BADF0, 32, -1, -1);   // got_left was cleared
    chk("pad_left_held", left_o, 24'h654321);
    chk("pad_right", right_o, 24'h0BADF0);
    chk("pad_no_pulse", 24'(n_valid - n0), 24'd0);
    send_pair(24'h1A2B3C, 24'h4D5E6F);
    chk("pad_recover", 24'(n_valid - n0), 24'd1);
    chk("pad_queue", 24'(exp_q.size()), 24'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frames();
    test_ws_err();
    test_clr_mid();
    test_pad_timeout();
    repeat (8) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
